// File: rtl/mem_arbiter.sv
// mem_arbiter: registered bridge from two caches' read/write miss channels onto one level-handshake memory port.
// Latency: grant one edge after req is sampled; master ack one edge after mem_ack is sampled.
// Backpressure: losing channels stay pending (req held, no ack) until granted; one memory access at a time.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_read_req,
  input  logic [ADDR_WIDTH-1:0] m0_read_addr,
  output logic [WIDTH-1:0]      m0_read_data,
  output logic                  m0_read_ack,
  input  logic                  m0_write_req,
  input  logic [ADDR_WIDTH-1:0] m0_write_addr,
  input  logic [WIDTH-1:0]      m0_write_data,
  output logic                  m0_write_ack,
  input  logic                  m1_read_req,
  input  logic [ADDR_WIDTH-1:0] m1_read_addr,
  output logic [WIDTH-1:0]      m1_read_data,
  output logic                  m1_read_ack,
  input  logic                  m1_write_req,
  input  logic [ADDR_WIDTH-1:0] m1_write_addr,
  input  logic [WIDTH-1:0]      m1_write_data,
  output logic                  m1_write_ack,
  output logic                  mem_enable,
  output logic                  mem_read_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data_in,
  output logic [WIDTH/8-1:0]    mem_byte_enable,
  input  logic [WIDTH-1:0]      mem_data_out,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic                  last;
  logic                  g_master;
  logic                  g_write;
  logic                  req0;
  logic                  req1;
  logic                  pick;
  logic                  pick_write;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [WIDTH-1:0]      pick_data;
  logic                  granted_req;

  assign mem_byte_enable = '1;

  // Round-robin between masters; inside a master the write-back goes first.
  always_comb begin
    req0       = m0_read_req | m0_write_req;
    req1       = m1_read_req | m1_write_req;
    pick       = (req0 && req1) ? ~last : req1;
    pick_write = pick ? m1_write_req : m0_write_req;
    pick_data  = pick ? m1_write_data : m0_write_data;
    if (pick)
      pick_addr = m1_write_req ? m1_write_addr : m1_read_addr;
    else
      pick_addr = m0_write_req ? m0_write_addr : m0_read_addr;
  end

  always_comb begin
    case ({g_master, g_write})
      2'b00:   granted_req = m0_read_req;
      2'b01:   granted_req = m0_write_req;
      2'b10:   granted_req = m1_read_req;
      default: granted_req = m1_write_req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last           <= 1'b1;
      g_master       <= 1'b0;
      g_write        <= 1'b0;
      mem_enable     <= 1'b0;
      mem_read_write <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      m0_read_data   <= '0;
      m1_read_data   <= '0;
      m0_read_ack    <= 1'b0;
      m0_write_ack   <= 1'b0;
      m1_read_ack    <= 1'b0;
      m1_write_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state          <= BUSY;
            g_master       <= pick;
            g_write        <= pick_write;
            last           <= pick;
            mem_enable     <= 1'b1;
            mem_read_write <= ~pick_write;
            mem_addr       <= pick_addr;
            if (pick_write)
              mem_data_in <= pick_data;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state      <= DONE;
            mem_enable <= 1'b0;
            case ({g_master, g_write})
              2'b00: begin
                m0_read_ack  <= 1'b1;
                m0_read_data <= mem_data_out;
              end
              2'b01: m0_write_ack <= 1'b1;
              2'b10: begin
                m1_read_ack  <= 1'b1;
                m1_read_data <= mem_data_out;
              end
              default: m1_write_ack <= 1'b1;
            endcase
          end
        end
        DONE: begin
          // Hold the ack until both the master and the memory have let go.
          if (!granted_req && !mem_ack) begin
            state        <= IDLE;
            m0_read_ack  <= 1'b0;
            m0_write_ack <= 1'b0;
            m1_read_ack  <= 1'b0;
            m1_write_ack <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four channel agents, a latency-programmable memory, and a transaction-level model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_read_req, m0_write_req, m1_read_req, m1_write_req;
  logic [31:0] m0_read_addr, m0_write_addr, m1_read_addr, m1_write_addr;
  logic [31:0] m0_write_data, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_ack, m0_write_ack, m1_read_ack, m1_write_ack;
  logic        mem_enable, mem_read_write;
  logic [31:0] mem_addr, mem_data_in;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_data_out;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // channel c = master*2 + write : 0 m0 read, 1 m0 write, 2 m1 read, 3 m1 write
  bit          req_b [4];
  logic [31:0] addr_b [4];
  logic [31:0] data_b [4];
  logic [63:0] cq [4][$];
  int          drop_after [4];
  int          hi_cnt [4];

  int          mem_lat;
  int          mem_cnt;
  logic [31:0] mem_store [logic [31:0]];

  assign m0_read_req   = req_b[0];
  assign m0_write_req  = req_b[1];
  assign m1_read_req   = req_b[2];
  assign m1_write_req  = req_b[3];
  assign m0_read_addr  = addr_b[0];
  assign m0_write_addr = addr_b[1];
  assign m1_read_addr  = addr_b[2];
  assign m1_write_addr = addr_b[3];
  assign m0_write_data = data_b[1];
  assign m1_write_data = data_b[3];

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_read_req(m0_read_req), .m0_read_addr(m0_read_addr), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
    .m0_write_req(m0_write_req), .m0_write_addr(m0_write_addr), .m0_write_data(m0_write_data), .m0_write_ack(m0_write_ack),
    .m1_read_req(m1_read_req), .m1_read_addr(m1_read_addr), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
    .m1_write_req(m1_write_req), .m1_write_addr(m1_write_addr), .m1_write_data(m1_write_data), .m1_write_ack(m1_write_ack),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_byte_enable(mem_byte_enable), .mem_data_out(mem_data_out), .mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int c);
    case (c)
      0:       return m0_read_ack;
      1:       return m0_write_ack;
      2:       return m1_read_ack;
      default: return m1_write_ack;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return 32'hA000_0000 | a;
  endfunction

  function automatic logic [63:0] gnt(input bit m, input bit w, input logic [31:0] a);
    return {30'd0, m, w, a};
  endfunction

  // Cache-side agents: raise a queued request, drop it on ack, never re-raise while ack is still high.
  initial begin
    for (int c = 0; c < 4; c++) begin
      req_b[c] = 1'b0; addr_b[c] = '0; data_b[c] = '0; drop_after[c] = 0; hi_cnt[c] = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (reset) begin
          req_b[c] = 1'b0;
          cq[c].delete();
        end else if (req_b[c] && (ack_of(c) || (drop_after[c] != 0 && hi_cnt[c] >= drop_after[c]))) begin
          req_b[c] = 1'b0;
          drop_after[c] = 0;
        end else if (req_b[c]) begin
          hi_cnt[c]++;
        end else if (!ack_of(c) && cq[c].size() > 0) begin
          logic [63:0] t;
          t = cq[c].pop_front();
          addr_b[c] = t[63:32];
          data_b[c] = t[31:0];
          req_b[c] = 1'b1;
          hi_cnt[c] = 0;
        end
      end
    end
  end

  // Memory: acks mem_lat cycles after enable is first seen, holds ack until enable falls.
  initial begin
    mem_ack = 1'b0; mem_data_out = '0; mem_cnt = 0; mem_lat = 3;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else if (mem_ack) begin
        if (!mem_enable) mem_ack = 1'b0;
      end else if (mem_enable) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_cnt = 0;
          mem_ack = 1'b1;
          if (mem_read_write) mem_data_out = rd(mem_addr);
          else                mem_store[mem_addr] = mem_data_in;
        end
      end
    end
  end

  // Transaction-level model: one owner of memory at a time, then an ack phase until req and mem_ack are both low.
  bit          model_live = 1'b0;
  bit          m_txn, m_acking;
  int          m_ch, m_last, cyc = 0;
  logic        m_rw;
  logic [31:0] m_addr, m_din;
  logic [31:0] m_rdata [2];
  logic [63:0] grants [$];

  initial forever begin
    @(posedge clk);
    model_live = 1'b1;
    cyc++;
    if (reset) begin
      m_txn = 0; m_acking = 0; m_last = 1; m_ch = 0;
      m_rw = 0; m_addr = '0; m_din = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else if (m_acking) begin
      if (!req_b[m_ch] && !mem_ack) m_acking = 0;
    end else if (m_txn) begin
      if (mem_ack) begin
        m_txn = 0;
        m_acking = 1;
        if (m_ch % 2 == 0) m_rdata[m_ch / 2] = mem_data_out;
      end
    end else begin
      bit want0, want1;
      int who;
      want0 = req_b[0] | req_b[1];
      want1 = req_b[2] | req_b[3];
      if (want0 || want1) begin
        who  = (want0 && want1) ? 1 - m_last : (want1 ? 1 : 0);
        m_ch = who * 2 + (req_b[who * 2 + 1] ? 1 : 0);
        m_rw = (m_ch % 2 == 0);
        m_addr = addr_b[m_ch];
        if (!m_rw) m_din = data_b[m_ch];
        m_last = who;
        m_txn = 1;
        grants.push_back(gnt(who[0], !m_rw, m_addr));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_live) begin
      logic [3:0] acks, exp_acks;
      acks = {m1_write_ack, m1_read_ack, m0_write_ack, m0_read_ack};
      exp_acks = m_acking ? (4'b0001 << m_ch) : 4'b0000;
      chk("mem_enable", mem_enable, m_txn);
      chk("mem_read_write", mem_read_write, m_rw);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data_in", mem_data_in, m_din);
      chk("mem_byte_enable", mem_byte_enable, 4'hF);
      chk("acks", acks, exp_acks);
      chk("ack_mutex", $countones(acks) <= 1, 1);
      chk("m0_read_data", m0_read_data, m_rdata[0]);
      chk("m1_read_data", m1_read_data, m_rdata[1]);
    end
  end

  task automatic wait_done(input int n, input string nm);
    int t;
    t = 0;
    while (!(grants.size() >= n && !m_txn && !m_acking &&
             cq[0].size() == 0 && cq[1].size() == 0 && cq[2].size() == 0 && cq[3].size() == 0 &&
             !req_b[0] && !req_b[1] && !req_b[2] && !req_b[3])) begin
      @(posedge clk); #1;
      t++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL %s timeout: grants %0d required %0d", nm, grants.size(), n);
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_acks"}, {m1_write_ack, m1_read_ack, m0_write_ack, m0_read_ack}, 4'b0000);
    chk({nm, "_enable"}, mem_enable, 1'b0);
    chk({nm, "_rw"}, mem_read_write, 1'b0);
    chk({nm, "_addr"}, mem_addr, 32'h0);
    chk({nm, "_din"}, mem_data_in, 32'h0);
    chk({nm, "_rdata0"}, m0_read_data, 32'h0);
    chk({nm, "_rdata1"}, m1_read_data, 32'h0);
    chk({nm, "_byte_en"}, mem_byte_enable, 4'hF);
  endtask

  initial begin
    int base, en_cyc, ack_cyc, pulse, m1_pos;
    bit got, seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single read, latency 3
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 3;
    cq[0].push_back({32'h0000_0004, 32'h0});
    en_cyc = -1; ack_cyc = -1; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (mem_enable && en_cyc < 0) en_cyc = cyc;
      if (m0_read_ack) begin got = 1; ack_cyc = cyc; end
    end
    chk("t1_ack_seen", got, 1'b1);
    chk("t1_latency", ack_cyc - en_cyc, 3);
    chk("t1_data", m0_read_data, 32'hA000_0004);
    chk("t1_rw_read", mem_read_write, 1'b1);
    @(negedge clk);
    chk("t1_ack_cleared", m0_read_ack, 1'b0);
    wait_done(base + 1, "t1");
    chk("t1_grant", grants[base], gnt(1'b0, 1'b0, 32'h4));

    // Write-before-read on both masters
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 2;
    cq[1].push_back({32'h0000_0010, 32'hDEAD_BEEF});
    cq[0].push_back({32'h0000_0020, 32'h0});
    wait_done(base + 2, "t2a");
    chk("t2_first_write", grants[base], gnt(1'b0, 1'b1, 32'h10));
    chk("t2_then_read", grants[base + 1], gnt(1'b0, 1'b0, 32'h20));
    chk("t2_read20", m0_read_data, 32'hA000_0020);
    @(posedge clk); #1;
    cq[0].push_back({32'h0000_0010, 32'h0});
    wait_done(base + 3, "t2b");
    chk("t2_readback", m0_read_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    cq[3].push_back({32'h0000_0044, 32'hCAFE_F00D});
    cq[2].push_back({32'h0000_0044, 32'h0});
    wait_done(base + 5, "t2c");
    chk("t2_m1_write_first", grants[base + 3], gnt(1'b1, 1'b1, 32'h44));
    chk("t2_m1_readback", m1_read_data, 32'hCAFE_F00D);

    // Round-robin from reset
    pulse_reset();
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 1;
    cq[0].push_back({32'h0000_0100, 32'h0});
    cq[0].push_back({32'h0000_0104, 32'h0});
    cq[2].push_back({32'h0000_0200, 32'h0});
    cq[2].push_back({32'h0000_0204, 32'h0});
    wait_done(base + 4, "t3");
    chk("t3_g0", grants[base],     gnt(1'b0, 1'b0, 32'h100));
    chk("t3_g1", grants[base + 1], gnt(1'b1, 1'b0, 32'h200));
    chk("t3_g2", grants[base + 2], gnt(1'b0, 1'b0, 32'h104));
    chk("t3_g3", grants[base + 3], gnt(1'b1, 1'b0, 32'h204));
    chk("t3_rdata0", m0_read_data, 32'hA000_0104);
    chk("t3_rdata1", m1_read_data, 32'hA000_0204);

    // Starvation: m1 read against five m0 writes
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 2;
    for (int i = 0; i < 5; i++) cq[1].push_back({32'h400 + 32'(4 * i), 32'h5000 + 32'(i)});
    cq[2].push_back({32'h0000_0500, 32'h0});
    wait_done(base + 6, "t4");
    m1_pos = -1;
    for (int i = base; i < grants.size(); i++)
      if (grants[i][33] && m1_pos < 0) m1_pos = i - base;
    chk("t4_m0_first", grants[base], gnt(1'b0, 1'b1, 32'h400));
    chk("t4_m1_position", m1_pos, 1);
    chk("t4_last_write", grants[base + 5], gnt(1'b0, 1'b1, 32'h410));

    // Reset two cycles into a read
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 4;
    cq[0].push_back({32'h0000_0300, 32'h0});
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (m_txn) got = 1;
    end
    chk("t5_granted", got, 1'b1);
    pulse_reset();
    @(negedge clk);
    chk_reset_outputs("t5_reset");
    @(posedge clk); #1;
    cq[2].push_back({32'h0000_0304, 32'h0});
    wait_done(base + 2, "t5");
    chk("t5_fresh_grant", grants[base + 1], gnt(1'b1, 1'b0, 32'h304));
    chk("t5_fresh_data", m1_read_data, 32'hA000_0304);

    // Early req drop during BUSY
    base = grants.size();
    @(posedge clk); #1;
    mem_lat = 4;
    drop_after[0] = 2;
    cq[0].push_back({32'h0000_0008, 32'h0});
    seen = 0; pulse = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m0_read_ack) begin seen = 1; pulse++; end
      else if (seen) break;
    end
    chk("t6_ack_pulse", pulse, 1);
    chk("t6_data", m0_read_data, 32'hA000_0008);
    wait_done(base + 1, "t6");
    chk("t6_grant", grants[base], gnt(1'b0, 1'b0, 32'h8));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
